// File: rtl/flow_ctrl_pkg.sv
// Shared types for the v1 instruction sequencer: instruction classes,
// sequencer states and a small classification helper.
package flow_ctrl_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_ALU   = 4'd1,
        OP_LOAD  = 4'd2,
        OP_STORE = 4'd3,
        OP_JUMP  = 4'd4,
        OP_HALT  = 4'd5,
        OP_EI    = 4'd6,
        OP_DI    = 4'd7,
        OP_RETI  = 4'd8
    } op_class_t;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_HALTED = 3'd4,
        ST_IRQ    = 3'd5
    } ctrl_state_t;

    // True for instructions that need a data-memory phase.
    function automatic logic is_mem_op(op_class_t op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/flow_ctrl_irq_ctx.sv
// Single-level interrupt context: interrupt enable, in-handler status and
// the saved return address. Set wins over clear when both are requested.
module irq_ctx #(
    parameter int A_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ie_set,
    input  logic               ie_clr,
    input  logic               isr_set,
    input  logic               isr_clr,
    input  logic               epc_capture,
    input  logic [A_WIDTH-1:0] epc_in,
    output logic               ie,
    output logic               in_isr,
    output logic [A_WIDTH-1:0] epc
);

    logic               ie_r;
    logic               in_isr_r;
    logic [A_WIDTH-1:0] epc_r;

    // Interrupt enable flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ie_r <= 1'b0;
        end else if (ie_set) begin
            ie_r <= 1'b1;
        end else if (ie_clr) begin
            ie_r <= 1'b0;
        end else begin
            ie_r <= ie_r;
        end
    end

    // Handler-active status flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_isr_r <= 1'b0;
        end else if (isr_set) begin
            in_isr_r <= 1'b1;
        end else if (isr_clr) begin
            in_isr_r <= 1'b0;
        end else begin
            in_isr_r <= in_isr_r;
        end
    end

    // Return address captured on interrupt entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epc_r <= {A_WIDTH{1'b0}};
        end else if (epc_capture) begin
            epc_r <= epc_in;
        end else begin
            epc_r <= epc_r;
        end
    end

    assign ie     = ie_r;
    assign in_isr = in_isr_r;
    assign epc    = epc_r;

endmodule

// File: rtl/flow_ctrl.sv
// Multi-cycle instruction sequencer: decides when the PC advances and where
// forced transfers go, strobes IR load / write-back / data memory, and
// sequences single-level interrupt entry and return.
module flow_ctrl
    import flow_ctrl_pkg::*;
#(
    parameter int                 A_WIDTH    = 8,
    parameter logic [A_WIDTH-1:0] IRQ_VECTOR = 8'hF0
) (
    input  logic               clk,
    input  logic               rst,
    input  op_class_t          op_class,
    input  logic [A_WIDTH-1:0] pc_addr,
    input  logic               mem_ready,
    input  logic               irq,
    output logic               pc_en,
    output logic               pc_force,
    output logic [A_WIDTH-1:0] force_addr,
    output logic               ir_load,
    output logic               mem_req,
    output logic               mem_we,
    output logic               reg_we,
    output logic               halted,
    output logic               in_isr,
    output logic               ie,
    output logic [A_WIDTH-1:0] epc,
    output ctrl_state_t        state
);

    ctrl_state_t        state_r;
    ctrl_state_t        next_state_s;
    ctrl_state_t        boundary_s;
    logic               pc_en_s;
    logic               pc_force_s;
    logic [A_WIDTH-1:0] force_addr_s;
    logic               ir_load_s;
    logic               mem_req_s;
    logic               mem_we_s;
    logic               reg_we_s;
    logic               ie_set_s;
    logic               ie_clr_s;
    logic               isr_set_s;
    logic               isr_clr_s;
    logic               epc_capture_s;
    logic               ie_s;
    logic [A_WIDTH-1:0] epc_s;

    irq_ctx #(.A_WIDTH(A_WIDTH)) u_irq_ctx (
        .clk         (clk),
        .rst         (rst),
        .ie_set      (ie_set_s),
        .ie_clr      (ie_clr_s),
        .isr_set     (isr_set_s),
        .isr_clr     (isr_clr_s),
        .epc_capture (epc_capture_s),
        .epc_in      (pc_addr),
        .ie          (ie_s),
        .in_isr      (in_isr),
        .epc         (epc_s)
    );

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; the boundary uses the enable value from before any
    // EI/DI/RETI update this cycle, so one more instruction follows EI/RETI.
    always_comb begin
        boundary_s   = (irq && ie_s) ? ST_IRQ : ST_FETCH;
        next_state_s = ST_FETCH;
        case (state_r)
            ST_FETCH:  next_state_s = ST_DECODE;
            ST_DECODE: next_state_s = ST_EXEC;
            ST_EXEC: begin
                if (is_mem_op(op_class)) begin
                    next_state_s = ST_MEM;
                end else if (op_class == OP_HALT) begin
                    next_state_s = ST_HALTED;
                end else begin
                    next_state_s = boundary_s;
                end
            end
            ST_MEM: begin
                if (mem_ready) begin
                    next_state_s = boundary_s;
                end else begin
                    next_state_s = ST_MEM;
                end
            end
            ST_HALTED: begin
                if (irq && ie_s) begin
                    next_state_s = ST_IRQ;
                end else begin
                    next_state_s = ST_HALTED;
                end
            end
            ST_IRQ:    next_state_s = ST_FETCH;
            default:   next_state_s = ST_FETCH;
        endcase
    end

    // Strobes and interrupt-context controls decoded from state and class.
    always_comb begin
        pc_en_s       = 1'b0;
        pc_force_s    = 1'b0;
        force_addr_s  = {A_WIDTH{1'b0}};
        ir_load_s     = 1'b0;
        mem_req_s     = 1'b0;
        mem_we_s      = 1'b0;
        reg_we_s      = 1'b0;
        ie_set_s      = 1'b0;
        ie_clr_s      = 1'b0;
        isr_set_s     = 1'b0;
        isr_clr_s     = 1'b0;
        epc_capture_s = 1'b0;
        case (state_r)
            ST_FETCH: ir_load_s = 1'b1;
            ST_EXEC: begin
                case (op_class)
                    OP_ALU: begin
                        reg_we_s = 1'b1;
                        pc_en_s  = 1'b1;
                    end
                    OP_LOAD, OP_STORE: pc_en_s = 1'b0;
                    OP_EI: begin
                        pc_en_s  = 1'b1;
                        ie_set_s = 1'b1;
                    end
                    OP_DI: begin
                        pc_en_s  = 1'b1;
                        ie_clr_s = 1'b1;
                    end
                    OP_RETI: begin
                        pc_en_s      = 1'b1;
                        pc_force_s   = 1'b1;
                        force_addr_s = epc_s;
                        ie_set_s     = 1'b1;
                        isr_clr_s    = 1'b1;
                    end
                    default: pc_en_s = 1'b1;
                endcase
            end
            ST_MEM: begin
                mem_req_s = 1'b1;
                mem_we_s  = (op_class == OP_STORE);
                if (mem_ready) begin
                    pc_en_s  = 1'b1;
                    reg_we_s = (op_class == OP_LOAD);
                end else begin
                    pc_en_s  = 1'b0;
                    reg_we_s = 1'b0;
                end
            end
            ST_IRQ: begin
                pc_en_s       = 1'b1;
                pc_force_s    = 1'b1;
                force_addr_s  = IRQ_VECTOR;
                ie_clr_s      = 1'b1;
                isr_set_s     = 1'b1;
                epc_capture_s = 1'b1;
            end
            default: pc_en_s = 1'b0;
        endcase
    end

    // Every strobe is suppressed while reset is asserted.
    assign pc_en      = pc_en_s & ~rst;
    assign pc_force   = pc_force_s & ~rst;
    assign force_addr = rst ? {A_WIDTH{1'b0}} : force_addr_s;
    assign ir_load    = ir_load_s & ~rst;
    assign mem_req    = mem_req_s & ~rst;
    assign mem_we     = mem_we_s & ~rst;
    assign reg_we     = reg_we_s & ~rst;
    assign halted     = (state_r == ST_HALTED) & ~rst;
    assign ie         = ie_s;
    assign epc        = epc_s;
    assign state      = state_r;

endmodule

// File: tb/tb_flow_ctrl.sv
// Scenario bench for flow_ctrl: per-cycle expected strobes are queued as
// instructions are planned and compared as the sequencer produces them.
module tb_flow_ctrl;
    import flow_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    op_class_t   op_class;
    logic [7:0]  pc_addr;
    logic        mem_ready;
    logic        irq;
    logic        pc_en, pc_force, ir_load, mem_req, mem_we, reg_we, halted, in_isr, ie;
    logic [7:0]  force_addr, epc;
    ctrl_state_t state;
    logic [6:0]  strobes;

    // Bench-side PC: advances on pc_en, takes forced target or jump target.
    logic [7:0]  pc_m;
    logic        jmp_taken;
    logic [7:0]  jmp_tgt;

    typedef struct {
        op_class_t   op;
        logic        rdy;
        logic        irq_v;
        ctrl_state_t st;
        logic [6:0]  vec;
        logic [7:0]  fa;
    } cyc_t;

    cyc_t plan_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    flow_ctrl #(.A_WIDTH(8), .IRQ_VECTOR(8'hF0)) dut (
        .clk(clk), .rst(rst), .op_class(op_class), .pc_addr(pc_addr),
        .mem_ready(mem_ready), .irq(irq), .pc_en(pc_en), .pc_force(pc_force),
        .force_addr(force_addr), .ir_load(ir_load), .mem_req(mem_req),
        .mem_we(mem_we), .reg_we(reg_we), .halted(halted), .in_isr(in_isr),
        .ie(ie), .epc(epc), .state(state)
    );

    always #5 clk = ~clk;

    assign strobes = {pc_en, pc_force, ir_load, mem_req, mem_we, reg_we, halted};
    assign pc_addr = pc_m;

    // PC model driven by the sequencer's strobes.
    always @(posedge clk or posedge rst) begin
        if (rst) pc_m <= 8'h00;
        else if (pc_en) pc_m <= pc_force ? force_addr :
                                ((op_class == OP_JUMP && jmp_taken) ? jmp_tgt : pc_m + 8'h01);
    end

    task automatic plan(op_class_t op, logic rdy, logic irq_v, ctrl_state_t st,
                        logic [6:0] vec, logic [7:0] fa);
        plan_q.push_back('{op, rdy, irq_v, st, vec, fa});
    endtask

    // Expected cycles of one instruction from FETCH to its last EXEC/MEM cycle.
    // Strobe order: pc_en pc_force ir_load mem_req mem_we reg_we halted.
    task automatic plan_instr(op_class_t op, int waits, logic irq_v, logic [7:0] ret_fa);
        plan(op, 1'b0, irq_v, ST_FETCH,  7'b0010000, 8'h00);
        plan(op, 1'b0, irq_v, ST_DECODE, 7'b0000000, 8'h00);
        case (op)
            OP_ALU: plan(op, 1'b0, irq_v, ST_EXEC, 7'b1000010, 8'h00);
            OP_LOAD, OP_STORE: begin
                plan(op, 1'b0, irq_v, ST_EXEC, 7'b0000000, 8'h00);
                for (int w = 0; w < waits; w++)
                    plan(op, 1'b0, irq_v, ST_MEM, {3'b000, 1'b1, (op == OP_STORE), 2'b00}, 8'h00);
                plan(op, 1'b1, irq_v, ST_MEM,
                     {1'b1, 2'b00, 1'b1, (op == OP_STORE), (op == OP_LOAD), 1'b0}, 8'h00);
            end
            OP_RETI: plan(op, 1'b0, irq_v, ST_EXEC, 7'b1100000, ret_fa);
            default: plan(op, 1'b0, irq_v, ST_EXEC, 7'b1000000, 8'h00);
        endcase
    endtask

    task automatic plan_irq();
        plan(OP_NOP, 1'b0, 1'b1, ST_IRQ, 7'b1100000, 8'hF0);
    endtask

    task automatic plan_halted(int n, logic irq_v);
        for (int i = 0; i < n; i++) plan(OP_NOP, 1'b0, irq_v, ST_HALTED, 7'b0000001, 8'h00);
    endtask

    task automatic test_reset();
        rst = 1'b1; op_class = OP_NOP; mem_ready = 1'b0; irq = 1'b0;
        jmp_taken = 1'b0; jmp_tgt = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (state !== ST_FETCH || strobes !== 7'b0000000) begin
            n_errors++;
            $display("FAIL reset_outputs: state=%0d strobes=%b, want state=%0d strobes=0000000",
                     state, strobes, ST_FETCH);
        end
        n_checks++;
        if ({ie, in_isr, epc} !== 10'd0) begin
            n_errors++;
            $display("FAIL reset_ctx: ie=%b in_isr=%b epc=%h, want 0 0 00", ie, in_isr, epc);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_alu_back_to_back();
        cyc_t c;
        plan_instr(OP_ALU, 0, 1'b0, 8'h00);
        plan_instr(OP_ALU, 0, 1'b0, 8'h00);
        for (int cyc = 1; plan_q.size() > 0; cyc++) begin
            c = plan_q.pop_front();
            op_class = c.op; mem_ready = c.rdy; irq = c.irq_v;
            @(negedge clk);
            n_checks++;
            if (state !== c.st || strobes !== c.vec || (c.vec[5] && force_addr !== c.fa)) begin
                n_errors++;
                $display("FAIL alu_b2b cycle %0d: state=%0d strobes=%b fa=%h, want state=%0d strobes=%b fa=%h",
                         cyc, state, strobes, force_addr, c.st, c.vec, c.fa);
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (pc_addr !== 8'h02) begin
            n_errors++;
            $display("FAIL alu_b2b_pc: pc=%h, want 02", pc_addr);
        end
    endtask

    task automatic test_mem();
        cyc_t c;
        plan_instr(OP_STORE, 2, 1'b0, 8'h00);
        plan_instr(OP_LOAD, 0, 1'b0, 8'h00);
        for (int cyc = 1; plan_q.size() > 0; cyc++) begin
            c = plan_q.pop_front();
            op_class = c.op; mem_ready = c.rdy; irq = c.irq_v;
            @(negedge clk);
            n_checks++;
            if (state !== c.st || strobes !== c.vec) begin
                n_errors++;
                $display("FAIL mem cycle %0d: state=%0d strobes=%b, want state=%0d strobes=%b",
                         cyc, state, strobes, c.st, c.vec);
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        n_checks++;
        if (pc_addr !== 8'h04) begin
            n_errors++;
            $display("FAIL mem_pc: pc=%h, want 04", pc_addr);
        end
    endtask

    task automatic test_irq_entry();
        cyc_t c;
        // irq already high during EI: the old enable (0) governs that boundary.
        plan_instr(OP_EI, 0, 1'b1, 8'h00);
        plan_instr(OP_ALU, 0, 1'b1, 8'h00);
        plan_irq();
        for (int cyc = 1; plan_q.size() > 0; cyc++) begin
            c = plan_q.pop_front();
            op_class = c.op; mem_ready = c.rdy; irq = c.irq_v;
            @(negedge clk);
            n_checks++;
            if (state !== c.st || strobes !== c.vec || (c.vec[5] && force_addr !== c.fa)) begin
                n_errors++;
                $display("FAIL irq_entry cycle %0d: state=%0d strobes=%b fa=%h, want state=%0d strobes=%b fa=%h",
                         cyc, state, strobes, force_addr, c.st, c.vec, c.fa);
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (epc !== 8'h06 || ie !== 1'b0 || in_isr !== 1'b1 || pc_addr !== 8'hF0) begin
            n_errors++;
            $display("FAIL irq_entry_ctx: epc=%h ie=%b in_isr=%b pc=%h, want 06 0 1 f0",
                     epc, ie, in_isr, pc_addr);
        end
    endtask

    task automatic test_reti();
        cyc_t c;
        plan_instr(OP_RETI, 0, 1'b1, 8'h06);
        for (int cyc = 1; plan_q.size() > 0; cyc++) begin
            c = plan_q.pop_front();
            op_class = c.op; mem_ready = c.rdy; irq = c.irq_v;
            @(negedge clk);
            n_checks++;
            if (state !== c.st || strobes !== c.vec || (c.vec[5] && force_addr !== c.fa)) begin
                n_errors++;
                $display("FAIL reti cycle %0d: state=%0d strobes=%b fa=%h, want state=%0d strobes=%b fa=%h",
                         cyc, state, strobes, force_addr, c.st, c.vec, c.fa);
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (ie !== 1'b1 || in_isr !== 1'b0 || pc_addr !== 8'h06 || state !== ST_FETCH) begin
            n_errors++;
            $display("FAIL reti_ctx: ie=%b in_isr=%b pc=%h state=%0d, want 1 0 06 %0d",
                     ie, in_isr, pc_addr, state, ST_FETCH);
        end
        // irq still pending: one instruction completes, then re-entry.
        plan_instr(OP_ALU, 0, 1'b1, 8'h00);
        plan_irq();
        for (int cyc = 1; plan_q.size() > 0; cyc++) begin
            c = plan_q.pop_front();
            op_class = c.op; mem_ready = c.rdy; irq = c.irq_v;
            @(negedge clk);
            n_checks++;
            if (state !== c.st || strobes !== c.vec || (c.vec[5] && force_addr !== c.fa)) begin
                n_errors++;
                $display("FAIL reti_reentry cycle %0d: state=%0d strobes=%b fa=%h, want state=%0d strobes=%b fa=%h",
                         cyc, state, strobes, force_addr, c.st, c.vec, c.fa);
            end
            @(posedge clk); #1;
        end
        irq = 1'b0;
        n_checks++;
        if (epc !== 8'h07 || ie !== 1'b0 || in_isr !== 1'b1) begin
            n_errors++;
            $display("FAIL reti_reentry_ctx: epc=%h ie=%b in_isr=%b, want 07 0 1", epc, ie, in_isr);
        end
    endtask

    task automatic test_halt_no_ie();
        cyc_t c;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        jmp_taken = 1'b1; jmp_tgt = 8'h10;
        plan_instr(OP_JUMP, 0, 1'b0, 8'h00);
        plan_instr(OP_HALT, 0, 1'b0, 8'h00);
        plan_halted(2, 1'b0);
        plan_halted(1, 1'b1);
        plan_halted(2, 1'b0);
        for (int cyc = 1; plan_q.size() > 0; cyc++) begin
            c = plan_q.pop_front();
            op_class = c.op; mem_ready = c.rdy; irq = c.irq_v;
            @(negedge clk);
            n_checks++;
            if (state !== c.st || strobes !== c.vec) begin
                n_errors++;
                $display("FAIL halt_no_ie cycle %0d: state=%0d strobes=%b, want state=%0d strobes=%b",
                         cyc, state, strobes, c.st, c.vec);
            end
            @(posedge clk); #1;
        end
        jmp_taken = 1'b0;
        n_checks++;
        if (pc_addr !== 8'h11 || ie !== 1'b0) begin
            n_errors++;
            $display("FAIL halt_no_ie_pc: pc=%h ie=%b, want 11 0", pc_addr, ie);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (state !== ST_FETCH || strobes !== 7'b0000000) begin
            n_errors++;
            $display("FAIL halt_rst_exit: state=%0d strobes=%b, want state=%0d strobes=0000000",
                     state, strobes, ST_FETCH);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_halt_irq();
        cyc_t c;
        plan_instr(OP_EI, 0, 1'b0, 8'h00);
        plan_instr(OP_DI, 0, 1'b0, 8'h00);
        for (int cyc = 1; plan_q.size() > 0; cyc++) begin
            c = plan_q.pop_front();
            op_class = c.op; mem_ready = c.rdy; irq = c.irq_v;
            @(negedge clk);
            n_checks++;
            if (state !== c.st || strobes !== c.vec) begin
                n_errors++;
                $display("FAIL ei_di cycle %0d: state=%0d strobes=%b, want state=%0d strobes=%b",
                         cyc, state, strobes, c.st, c.vec);
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (ie !== 1'b0 || pc_addr !== 8'h02) begin
            n_errors++;
            $display("FAIL di_clears_ie: ie=%b pc=%h, want 0 02", ie, pc_addr);
        end
        jmp_taken = 1'b1; jmp_tgt = 8'h10;
        plan_instr(OP_EI, 0, 1'b0, 8'h00);
        plan_instr(OP_JUMP, 0, 1'b0, 8'h00);
        plan_instr(OP_HALT, 0, 1'b0, 8'h00);
        plan_halted(5, 1'b0);
        plan_halted(1, 1'b1);
        plan_irq();
        for (int cyc = 1; plan_q.size() > 0; cyc++) begin
            c = plan_q.pop_front();
            op_class = c.op; mem_ready = c.rdy; irq = c.irq_v;
            @(negedge clk);
            n_checks++;
            if (state !== c.st || strobes !== c.vec || (c.vec[5] && force_addr !== c.fa)) begin
                n_errors++;
                $display("FAIL halt_irq cycle %0d: state=%0d strobes=%b fa=%h, want state=%0d strobes=%b fa=%h",
                         cyc, state, strobes, force_addr, c.st, c.vec, c.fa);
            end
            @(posedge clk); #1;
        end
        irq = 1'b0; jmp_taken = 1'b0;
        n_checks++;
        if (epc !== 8'h11 || ie !== 1'b0 || in_isr !== 1'b1 || pc_addr !== 8'hF0) begin
            n_errors++;
            $display("FAIL halt_irq_ctx: epc=%h ie=%b in_isr=%b pc=%h, want 11 0 1 f0",
                     epc, ie, in_isr, pc_addr);
        end
    endtask

    task automatic test_reset_in_mem();
        cyc_t c;
        plan_instr(OP_LOAD, 1, 1'b0, 8'h00);
        c = plan_q.pop_back();
        for (int cyc = 1; plan_q.size() > 0; cyc++) begin
            c = plan_q.pop_front();
            op_class = c.op; mem_ready = c.rdy; irq = c.irq_v;
            @(negedge clk);
            n_checks++;
            if (state !== c.st || strobes !== c.vec) begin
                n_errors++;
                $display("FAIL load_wait cycle %0d: state=%0d strobes=%b, want state=%0d strobes=%b",
                         cyc, state, strobes, c.st, c.vec);
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (mem_req !== 1'b1 || state !== ST_MEM) begin
            n_errors++;
            $display("FAIL mem_still_waiting: mem_req=%b state=%0d, want 1 %0d", mem_req, state, ST_MEM);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || reg_we !== 1'b0 || pc_en !== 1'b0 || state !== ST_FETCH) begin
            n_errors++;
            $display("FAIL rst_in_mem: mem_req=%b reg_we=%b pc_en=%b state=%0d, want 0 0 0 %0d",
                     mem_req, reg_we, pc_en, state, ST_FETCH);
        end
        n_checks++;
        if (ie !== 1'b0 || in_isr !== 1'b0 || epc !== 8'h00) begin
            n_errors++;
            $display("FAIL rst_in_mem_ctx: ie=%b in_isr=%b epc=%h, want 0 0 00", ie, in_isr, epc);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        plan_instr(OP_ALU, 0, 1'b0, 8'h00);
        for (int cyc = 1; plan_q.size() > 0; cyc++) begin
            c = plan_q.pop_front();
            op_class = c.op; mem_ready = c.rdy; irq = c.irq_v;
            @(negedge clk);
            n_checks++;
            if (state !== c.st || strobes !== c.vec) begin
                n_errors++;
                $display("FAIL restart cycle %0d: state=%0d strobes=%b, want state=%0d strobes=%b",
                         cyc, state, strobes, c.st, c.vec);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_alu_back_to_back();
        test_mem();
        test_irq_entry();
        test_reti();
        test_halt_no_ie();
        test_halt_irq();
        test_reset_in_mem();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
